// File: rtl/key_debounce_sync.sv
// Button and switch conditioner: two-flop synchronizers, one debounce FSM per
// key, and a switch snapshot captured on every accepted press.
module key_debounce_sync #(
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SW_W            = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw_n,
    input  logic [SW_W-1:0]    sw_raw,
    output logic [NUM_BTN-1:0] btn_db_n,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [SW_W-1:0]    sw_sync,
    output logic [SW_W-1:0]    sw_snap,
    output logic [2:0]         snap_src
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        REL,
        PWAIT,
        PRS,
        RWAIT
    } state_e;

    logic [NUM_BTN-1:0] btn_meta_q, btn_meta_d;
    logic [NUM_BTN-1:0] btn_sync_q, btn_sync_d;
    logic [SW_W-1:0]    sw_meta_q, sw_meta_d;
    logic [SW_W-1:0]    sw_sync_q, sw_sync_d;

    state_e             state_q [NUM_BTN];
    state_e             state_d [NUM_BTN];
    logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d   [NUM_BTN];

    logic [NUM_BTN-1:0] db_n_q, db_n_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [SW_W-1:0]    snap_q, snap_d;
    logic [2:0]         src_q, src_d;
    logic               snap_taken;

    always_comb begin
        btn_meta_d = btn_raw_n;
        btn_sync_d = btn_meta_q;
        sw_meta_d  = sw_raw;
        sw_sync_d  = sw_meta_q;

        press_d    = '0;
        release_d  = '0;
        db_n_d     = db_n_q;
        snap_d     = snap_q;
        src_d      = src_q;
        snap_taken = 1'b0;

        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            // cnt holds the number of consecutive samples at the new level
            unique case (state_q[i])
                REL: begin
                    if (!btn_sync_q[i]) begin
                        state_d[i] = PWAIT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                PWAIT: begin
                    if (btn_sync_q[i]) begin
                        state_d[i] = REL;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] >= CNT_LAST) begin
                        state_d[i] = PRS;
                        cnt_d[i]   = '0;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                PRS: begin
                    if (btn_sync_q[i]) begin
                        state_d[i] = RWAIT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                RWAIT: begin
                    if (!btn_sync_q[i]) begin
                        state_d[i]   = PRS;
                        cnt_d[i]     = '0;
                    end else if (cnt_q[i] >= CNT_LAST) begin
                        state_d[i]   = REL;
                        cnt_d[i]     = '0;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i]     = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = REL;
                    cnt_d[i]   = '0;
                end
            endcase

            db_n_d[i] = (state_d[i] == REL) || (state_d[i] == PWAIT);

            // Lowest-index channel pressing this cycle owns the snapshot
            if (press_d[i] && !snap_taken) begin
                snap_taken = 1'b1;
                snap_d     = sw_sync_q;
                src_d      = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= '1;
            btn_sync_q <= '1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            db_n_q     <= '1;
            press_q    <= '0;
            release_q  <= '0;
            snap_q     <= '0;
            src_q      <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= REL;
                cnt_q[i]   <= '0;
            end
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            db_n_q     <= db_n_d;
            press_q    <= press_d;
            release_q  <= release_d;
            snap_q     <= snap_d;
            src_q      <= src_d;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign btn_db_n    = db_n_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign sw_sync     = sw_sync_q;
    assign sw_snap     = snap_q;
    assign snap_src    = src_q;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chk
        a_cnt_sat: assert property (@(posedge clk) disable iff (!rst_n)
            cnt_q[g] <= CNT_LAST);
        a_press_level: assert property (@(posedge clk) disable iff (!rst_n)
            btn_press[g] |-> !btn_db_n[g]);
    end

    a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n)
        (btn_press & btn_release) == '0);

endmodule
